de2i_150_qsys_button_debounce: RTL and testbench

//  Per-bit synchroniser and debouncer for the DE2i-150 KEY[3:0] pushbuttons.

---
 rtl/de2i_150_qsys_button_debounce.sv | 113 +++++++++++
 tb/tb_de2i_150_qsys_button_debounce.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2i_150_qsys_button_debounce.sv
// Per-bit 2-flop synchroniser and stable-time debouncer for the DE2i-150 KEY pushbuttons.
// Optional press/release event pulses are enabled by defining BUTTON_DEBOUNCE_EVENT_EN.
module de2i_150_qsys_button_debounce #(
  parameter int unsigned     WIDTH           = 4,
  parameter int unsigned     CNT_W           = 20,
  parameter int unsigned     DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] busy
`ifdef BUTTON_DEBOUNCE_EVENT_EN
  ,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
`endif
);

  typedef enum logic {
    STABLE,
    COUNTING
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 2) || (((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0)) begin : g_param_check
    $error("debounce: DEBOUNCE_CYCLES must be >= 2 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             key_q;
    logic             busy_q;

    // Any sample back at the committed level drops to STABLE, so the count restarts.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state  <= STABLE;
        cnt    <= '0;
        key_q  <= RESET_LEVEL[i];
        busy_q <= 1'b0;
      end else begin
        case (state)
          STABLE: begin
            if (s2[i] != key_q) begin
              state  <= COUNTING;
              cnt    <= CNT_W'(1);
              busy_q <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          COUNTING: begin
            if (s2[i] == key_q) begin
              state  <= STABLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end else if (cnt == LAST) begin
              key_q  <= s2[i];
              state  <= STABLE;
              cnt    <= '0;
              busy_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= STABLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end

    assign key_out[i] = key_q;
    assign busy[i]    = busy_q;
  end

`ifdef BUTTON_DEBOUNCE_EVENT_EN
  logic [WIDTH-1:0] key_d;

  // Pulses fire on the cycle after key_out changes, from a delayed copy of key_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_d         <= RESET_LEVEL;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      key_d         <= key_out;
      press_pulse   <= key_d & ~key_out;
      release_pulse <= ~key_d & key_out;
    end
  end
`endif

endmodule

// File: tb/tb_de2i_150_qsys_button_debounce.sv
// Self-checking bench for de2i_150_qsys_button_debounce (DEBOUNCE_CYCLES=8, CNT_W=4) using
// a run-length reference model of the debounce rule.
module tb_de2i_150_qsys_button_debounce;
  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] key_in;
  logic [W-1:0] key_out;
  logic [W-1:0] busy;
`ifdef BUTTON_DEBOUNCE_EVENT_EN
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: input pipeline, committed level, run of differing samples.
  logic [W-1:0] m_s1, m_s2, m_ko, m_busy, m_kd, m_press, m_rel;
  int           run[W];

  de2i_150_qsys_button_debounce #(
    .WIDTH(4),
    .CNT_W(4),
    .DEBOUNCE_CYCLES(8),
    .RESET_LEVEL(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_in(key_in),
    .key_out(key_out),
    .busy(busy)
`ifdef BUTTON_DEBOUNCE_EVENT_EN
    ,
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_ko = 4'hF; m_kd = 4'hF;
    m_busy = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // Advance one clock edge and update the model: a level commits once D consecutive
  // synchronised samples differ from the committed level.
  task automatic tick();
    logic [W-1:0] kin;
    logic [W-1:0] ko_old;
    @(posedge clk);
    kin = key_in;
    if (!reset_n) begin
      model_reset();
    end else begin
      ko_old  = m_ko;
      m_press = m_kd & ~ko_old;
      m_rel   = ~m_kd & ko_old;
      m_kd    = ko_old;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_ko[i]) begin
          run[i]++;
          if (run[i] == D) begin
            m_ko[i] = m_s2[i];
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
        m_busy[i] = (run[i] != 0);
      end
      m_s2 = m_s1;
      m_s1 = kin;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_in  = 4'h0;
    model_reset();
    #1;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (key_out !== 4'hF) begin errors++; $display("FAIL reset_key_out e=%0d got=%h exp=%h", e, key_out, 4'hF); end
      checks++;
      if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy e=%0d got=%h exp=%h", e, busy, 4'h0); end
    end
    key_in  = 4'hF;
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (key_out !== 4'hF) begin errors++; $display("FAIL post_reset_key_out e=%0d got=%h exp=%h", e, key_out, 4'hF); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL post_reset_busy e=%0d got=%h exp=%h", e, busy, m_busy); end
    end
  endtask

  task automatic test_clean_press();
    int commit = -1, rise = -1, fall = -1;
    key_in[0] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL press_key_out e=%0d got=%h exp=%h", e, key_out, m_ko); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL press_busy e=%0d got=%h exp=%h", e, busy, m_busy); end
      if (commit < 0 && key_out[0] == 1'b0) commit = e;
      if (rise < 0 && busy[0] == 1'b1) rise = e;
      if (rise >= 0 && fall < 0 && busy[0] == 1'b0) fall = e;
    end
    checks++;
    if (commit !== D + 2) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", commit, D + 2); end
    checks++;
    if (rise !== 3) begin errors++; $display("FAIL busy_rise_edge got=%0d exp=%0d", rise, 3); end
    checks++;
    if (fall !== D + 2) begin errors++; $display("FAIL busy_fall_edge got=%0d exp=%0d", fall, D + 2); end
    key_in[0] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL release_key_out e=%0d got=%h exp=%h", e, key_out, m_ko); end
    end
    checks++;
    if (key_out !== 4'hF) begin errors++; $display("FAIL release_final got=%h exp=%h", key_out, 4'hF); end
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 30; e++) begin
      if (e <= 7) key_in[1] = 1'b0;
      else if (e == 8) key_in[1] = 1'b1;
      else if (e <= 15) key_in[1] = 1'b0;
      else key_in[1] = 1'b1;
      tick();
      checks++;
      if (key_out[1] !== 1'b1) begin errors++; $display("FAIL bounce_key_out1 e=%0d got=%b exp=%b", e, key_out[1], 1'b1); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL bounce_busy e=%0d got=%h exp=%h", e, busy, m_busy); end
    end
  endtask

  task automatic test_multi();
    int c2 = -1, c3 = -1;
    key_in[3:2] = 2'b00;
    for (int e = 1; e <= 18; e++) begin
      if (e == 4) key_in[3] = 1'b1;
      if (e == 5) key_in[3] = 1'b0;
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL multi_key_out e=%0d got=%h exp=%h", e, key_out, m_ko); end
      if (c2 < 0 && key_out[2] == 1'b0) c2 = e;
      if (c3 < 0 && key_out[3] == 1'b0) c3 = e;
    end
    checks++;
    if (c2 !== D + 2) begin errors++; $display("FAIL multi_commit2 got=%0d exp=%0d", c2, D + 2); end
    // Last high sample of bit 3 is taken at edge 4; the clean step starts at edge 5.
    checks++;
    if (c3 !== 4 + D + 2) begin errors++; $display("FAIL multi_commit3 got=%0d exp=%0d", c3, 4 + D + 2); end
    key_in = 4'hF;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL multi_release e=%0d got=%h exp=%h", e, key_out, m_ko); end
    end
  endtask

  task automatic test_reset_mid();
    int commit = -1;
    key_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL mid_busy e=%0d got=%h exp=%h", e, busy, m_busy); end
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (key_out !== 4'hF) begin errors++; $display("FAIL mid_async_key_out got=%h exp=%h", key_out, 4'hF); end
    checks++;
    if (busy !== 4'h0) begin errors++; $display("FAIL mid_async_busy got=%h exp=%h", busy, 4'h0); end
    tick();
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL mid_key_out e=%0d got=%h exp=%h", e, key_out, m_ko); end
      if (commit < 0 && key_out[0] == 1'b0) commit = e;
    end
    checks++;
    if (commit !== D + 2) begin errors++; $display("FAIL mid_latency got=%0d exp=%0d", commit, D + 2); end
    key_in[0] = 1'b1;
    for (int e = 1; e <= 14; e++) tick();
    checks++;
    if (key_out !== 4'hF) begin errors++; $display("FAIL mid_final got=%h exp=%h", key_out, 4'hF); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) key_in[i] = ~key_in[i];
      tick();
      checks++;
      if (key_out !== m_ko) begin errors++; $display("FAIL rand_key_out c=%0d got=%h exp=%h", c, key_out, m_ko); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL rand_busy c=%0d got=%h exp=%h", c, busy, m_busy); end
`ifdef BUTTON_DEBOUNCE_EVENT_EN
      checks++;
      if (press_pulse !== m_press || release_pulse !== m_rel) begin
        errors++;
        $display("FAIL rand_pulses c=%0d got=%h/%h exp=%h/%h", c, press_pulse, release_pulse, m_press, m_rel);
      end
`endif
    end
    key_in = 4'hF;
    for (int e = 1; e <= 20; e++) tick();
    checks++;
    if (key_out !== 4'hF) begin errors++; $display("FAIL rand_settle got=%h exp=%h", key_out, 4'hF); end
  endtask

`ifdef BUTTON_DEBOUNCE_EVENT_EN
  task automatic test_events();
    int np = 0, nr = 0, pe = -1, re = -1;
    for (int ph = 0; ph < 2; ph++) begin
      key_in[2] = (ph == 1);
      for (int e = 1; e <= 14; e++) begin
        tick();
        checks++;
        if (press_pulse !== m_press || release_pulse !== m_rel) begin
          errors++;
          $display("FAIL event_pulses ph=%0d e=%0d got=%h/%h exp=%h/%h", ph, e, press_pulse, release_pulse, m_press, m_rel);
        end
        if (press_pulse != 4'h0) begin
          np++;
          if (press_pulse == 4'h4 && ph == 0) pe = e;
        end
        if (release_pulse != 4'h0) begin
          nr++;
          if (release_pulse == 4'h4 && ph == 1) re = e;
        end
      end
    end
    checks++;
    if (np !== 1 || pe !== D + 3) begin errors++; $display("FAIL press_pulse count=%0d edge=%0d exp=1/%0d", np, pe, D + 3); end
    checks++;
    if (nr !== 1 || re !== D + 3) begin errors++; $display("FAIL release_pulse count=%0d edge=%0d exp=1/%0d", nr, re, D + 3); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_random();
`ifdef BUTTON_DEBOUNCE_EVENT_EN
    test_events();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
